// File: rtl/uart_mem_loader.sv
// UART-to-BRAM bulk loader/dumper for sub-byte RAM words.
// Define UART_MEM_LOADER_CHECKSUM_EN to append a mod-256 checksum byte to each dump.
module uart_mem_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int DEPTH        = 40000,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_load_in,
    input  logic                  start_dump_in,
    input  logic [ADDR_WIDTH:0]   length_in,
    input  logic                  rx_valid_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  tx_busy_in,
    output logic                  tx_trigger_out,
    output logic [7:0]            tx_byte_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_waddr_out,
    output logic [WORD_WIDTH-1:0] mem_wdata_out,
    output logic [ADDR_WIDTH-1:0] mem_raddr_out,
    input  logic [WORD_WIDTH-1:0] mem_rdata_in,
    output logic [ADDR_WIDTH:0]   words_loaded_out,
    output logic [1:0]            state_out,
    output logic                  done_out,
    output logic                  overflow_out
);

    localparam int K = 8 / WORD_WIDTH;
    localparam logic [3:0]          K4      = 4'(K);
    localparam logic [ADDR_WIDTH:0] K_W     = (ADDR_WIDTH+1)'(K);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        SEND,
        HOLD,
        FIN
    } sub_t;

    state_t state;
    sub_t   sub;

    logic [ADDR_WIDTH:0]     target;
    logic [ADDR_WIDTH:0]     wp;
    logic [ADDR_WIDTH:0]     rp;
    logic [3:0]              cnt;
    logic [3:0]              nb;
    logic [3:0]              issued;
    logic [3:0]              rcv;
    logic [7:0]              sh;
    logic [7:0]              acc;
    logic                    rd_issue;
    logic [READ_LATENCY-1:0] vld;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    logic [7:0]              sum;
    logic                    cks_phase;
`endif

    logic [ADDR_WIDTH:0] len_clip;
    logic [ADDR_WIDTH:0] rem;
    logic [ADDR_WIDTH:0] wp_inc;
    logic [3:0]          nb_next;
    logic [7:0]          src;
    logic                do_wr;

    // src is the byte feeding the unpacker: live rx byte or the shifted remainder
    always_comb begin
        len_clip = (length_in > DEPTH_W) ? DEPTH_W : length_in;
        rem      = words_loaded_out - ((state == DUMP) ? rp : '0);
        nb_next  = (rem >= K_W) ? K4 : 4'(rem);
        src      = (cnt != 4'd0) ? sh : rx_byte_in;
        do_wr    = (cnt != 4'd0) || rx_valid_in;
        wp_inc   = wp + ONE_W;
    end

    assign state_out = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            sub              <= FETCH;
            target           <= '0;
            wp               <= '0;
            rp               <= '0;
            cnt              <= '0;
            nb               <= '0;
            issued           <= '0;
            rcv              <= '0;
            sh               <= '0;
            acc              <= '0;
            rd_issue         <= 1'b0;
            vld              <= '0;
            tx_trigger_out   <= 1'b0;
            tx_byte_out      <= '0;
            mem_we_out       <= 1'b0;
            mem_waddr_out    <= '0;
            mem_wdata_out    <= '0;
            mem_raddr_out    <= '0;
            words_loaded_out <= '0;
            done_out         <= 1'b0;
            overflow_out     <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            sum              <= '0;
            cks_phase        <= 1'b0;
`endif
        end else begin
            mem_we_out     <= 1'b0;
            tx_trigger_out <= 1'b0;
            done_out       <= 1'b0;
            rd_issue       <= 1'b0;
            vld[0]         <= rd_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end

            unique case (state)
                IDLE: begin
                    if (start_load_in) begin
                        overflow_out <= (length_in > DEPTH_W);
                        target       <= len_clip;
                        wp           <= '0;
                        cnt          <= '0;
                        if (len_clip == '0) begin
                            done_out         <= 1'b1;
                            words_loaded_out <= '0;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (start_dump_in) begin
                        if (words_loaded_out == '0) begin
                            done_out <= 1'b1;
                        end else begin
                            state  <= DUMP;
                            sub    <= FETCH;
                            rp     <= '0;
                            nb     <= nb_next;
                            issued <= '0;
                            rcv    <= '0;
                            acc    <= '0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                            sum       <= '0;
                            cks_phase <= 1'b0;
`endif
                        end
                    end
                end

                LOAD: begin
                    if ((cnt != 4'd0) && rx_valid_in) begin
                        overflow_out <= 1'b1;
                    end
                    if (do_wr) begin
                        mem_we_out    <= 1'b1;
                        mem_waddr_out <= wp[ADDR_WIDTH-1:0];
                        mem_wdata_out <= src[WORD_WIDTH-1:0];
                        sh            <= src >> WORD_WIDTH;
                        wp            <= wp_inc;
                        cnt           <= (cnt != 4'd0) ? cnt - 4'd1 : K4 - 4'd1;
                        // reaching the target discards the rest of the byte
                        if (wp_inc == target) begin
                            cnt              <= '0;
                            state            <= IDLE;
                            done_out         <= 1'b1;
                            words_loaded_out <= target;
                        end
                    end
                end

                DUMP: begin
                    unique case (sub)
                        FETCH: begin
                            if (issued != nb) begin
                                rd_issue      <= 1'b1;
                                mem_raddr_out <= rp[ADDR_WIDTH-1:0];
                                rp            <= rp + ONE_W;
                                issued        <= issued + 4'd1;
                            end
                            if (vld[READ_LATENCY-1]) begin
                                acc[rcv*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata_in;
                                rcv <= rcv + 4'd1;
                                if (rcv + 4'd1 == nb) begin
                                    sub <= WAIT;
                                end
                            end
                        end
                        WAIT: begin
                            if (!tx_busy_in) begin
                                tx_trigger_out <= 1'b1;
                                tx_byte_out    <= acc;
                                sub            <= SEND;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                                if (!cks_phase) begin
                                    sum <= sum + acc;
                                end
`endif
                            end
                        end
                        SEND: begin
                            sub <= HOLD;
                        end
                        HOLD: begin
                            if (rp != words_loaded_out) begin
                                sub    <= FETCH;
                                nb     <= nb_next;
                                issued <= '0;
                                rcv    <= '0;
                                acc    <= '0;
                            end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                            else if (!cks_phase) begin
                                cks_phase <= 1'b1;
                                acc       <= sum;
                                sub       <= WAIT;
                            end
`endif
                            else begin
                                sub <= FIN;
                            end
                        end
                        FIN: begin
                            if (!tx_busy_in) begin
                                done_out <= 1'b1;
                                state    <= IDLE;
                            end
                        end
                        default: sub <= FETCH;
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Parametrised UART-to-BRAM bulk loader and dumper.
- Sits between uart_receive / uart_transmit and one dual-port BRAM.
- LOAD mode: unpacks received bytes into WORD_WIDTH-bit RAM words and writes them sequentially.
- DUMP mode: reads the stored words back, repacks them into bytes and streams them to the transmitter under busy handshake.
- Replaces ad-hoc evt_counter addressing with a single controlled block that supports any sub-byte word width.

Parameters:
- WORD_WIDTH, 8, RAM word width; legal values 1, 2, 4, 8. K = 8/WORD_WIDTH words per byte.
- DEPTH, 40000, RAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- READ_LATENCY, 2, cycles from mem_raddr_out to valid mem_rdata_in (output-registered BRAM).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start_load_in  input  1  pulse; begin LOAD (honoured only in IDLE).
- start_dump_in  input  1  pulse; begin DUMP (honoured only in IDLE).
- length_in  input  ADDR_WIDTH+1  words to load; sampled on an accepted start_load_in.
- rx_valid_in  input  1  one-cycle strobe from uart_receive.
- rx_byte_in  input  8  received byte.
- tx_busy_in  input  1  busy_out of uart_transmit.
- tx_trigger_out  output  1  one-cycle transmit strobe.
- tx_byte_out  output  8  byte to transmit; stable while tx_trigger_out is high.
- mem_we_out  output  1  write enable.
- mem_waddr_out  output  ADDR_WIDTH  write address.
- mem_wdata_out  output  WORD_WIDTH  write data.
- mem_raddr_out  output  ADDR_WIDTH  read address.
- mem_rdata_in  input  WORD_WIDTH  read data.
- words_loaded_out  output  ADDR_WIDTH+1  words written by the last LOAD.
- state_out  output  2  0=IDLE, 1=LOAD, 2=DUMP.
- done_out  output  1  one-cycle pulse when LOAD or DUMP completes.
- overflow_out  output  1  sticky error flag; cleared by reset or an accepted start_load_in.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - words_loaded_out=0, overflow_out=0.
  - Reset mid-operation aborts immediately; no further mem writes or tx triggers.
- IDLE:
  - start_load_in and start_dump_in in the same cycle: load wins.
  - Starts arriving in any non-IDLE state are ignored.
- LOAD entry:
  - Write pointer wp=0; target T=min(length_in, DEPTH).
  - length_in>DEPTH sets overflow_out.
  - T=0 pulses done_out on the next cycle and returns to IDLE.
- LOAD per byte:
  - Each rx_valid_in starts an unpack of K words, LSB-first: word j = rx_byte_in[j*WORD_WIDTH +: WORD_WIDTH].
  - Words are written on K consecutive cycles, beginning the cycle after rx_valid_in; mem_we_out is high once per word and wp increments per word.
  - When wp reaches T: remaining sub-words of that byte are discarded, words_loaded_out=T, done_out pulses, return to IDLE.
  - A rx_valid_in arriving while an unpack is in progress is dropped and sets overflow_out.
- DUMP:
  - Entered with N=words_loaded_out; N=0 pulses done_out next cycle.
  - Words 0..N-1 are read in order and accumulated LSB-first into a byte; the partial final byte is zero-padded in its upper bits.
  - Sub-states:
    - FETCH: issue K reads, pipelined one per cycle, honouring READ_LATENCY.
    - WAIT: wait for tx_busy_in==0.
    - SEND: tx_trigger_out=1 for exactly one cycle.
    - HOLD: ignore tx_busy_in for one cycle, so the transmitter can raise busy.
  - After the last byte is sent and tx_busy_in falls, done_out pulses and the block returns to IDLE.
- mem_we_out is never high in DUMP. tx_trigger_out is never high outside DUMP.
- No simultaneous read/write hazard exists, because modes are exclusive.

Optional Feature:
- Macro: UART_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - DUMP appends one extra byte: the 8-bit sum (mod 256) of all data bytes sent, including the zero-padded final byte.
  - That byte is sent with the same WAIT/SEND/HOLD handshake.
  - done_out pulses only after the checksum byte completes.
- When undefined: no trailing byte and no checksum logic.

Test Plan:
- WORD_WIDTH=4, DEPTH=16; load length 4 with bytes 0xA5, 0x3C -> writes addr0=0x5, 1=0xA, 2=0xC, 3=0x3; done_out pulse; words_loaded_out=4.
- Then dump, with busy modelled for 10 cycles after each trigger -> tx bytes 0xA5, 0x3C, triggers ≥11 cycles apart; with CHECKSUM_EN a third byte 0xE1.
- Load length 3 with bytes 0xA5, 0x3C -> third write 0xC, no fourth write; dump -> bytes 0xA5, 0x0C.
- WORD_WIDTH=1, length_in=20, DEPTH=16 -> overflow_out=1; exactly 16 writes; words_loaded_out=16; two bytes dumped.
- start_load_in and start_dump_in asserted together in IDLE -> state_out=1; a second start_dump_in during LOAD is ignored.
- rst_in asserted mid-DUMP -> next cycle state_out=0, no tx_trigger_out, words_loaded_out=0, overflow_out=0.
